// File: rtl/fl_netcope_adder_ctrl.sv
// fl_netcope_adder_ctrl: prepends one NetCOPE header word to each FrameLink frame, with bypass and frame counter
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   EN                  1 = insert header, 0 = bypass (sampled only in IDLE)
//   RX_*                input FrameLink (active-low framing/handshake)
//   HDR_DATA, HDR_VLD   header word for the next frame and its valid flag
//   HDR_NEXT            one-cycle pop strobe to the header source
//   TX_*                output FrameLink (active-low framing/handshake)
//   FRAME_CNT           number of frames sent with an inserted header, wrapping
module fl_netcope_adder_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    localparam int REM_W     = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [REM_W-1:0]      RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    input  logic [DATA_WIDTH-1:0] HDR_DATA,
    input  logic                  HDR_VLD,
    output logic                  HDR_NEXT,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [REM_W-1:0]      TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT
);
    typedef enum logic [1:0] {IDLE, HDR, DATA, BYPASS} state_t;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   frame_pending, rx_last, in_hdr, pass;
    assign frame_pending = !RX_SRC_RDY_N && !RX_SOF_N;
    // In DATA/BYPASS the RX ready is the TX ready, so a last-word transfer needs both sides.
    assign rx_last       = !RX_SRC_RDY_N && !TX_DST_RDY_N && !RX_EOF_N;
    assign in_hdr        = state_q == HDR;
    assign pass          = state_q == DATA || state_q == BYPASS;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   state_d = !frame_pending ? IDLE : !EN ? BYPASS : HDR_VLD ? HDR : IDLE;
            HDR:    state_d = !TX_DST_RDY_N ? DATA : HDR;
            DATA: begin
                state_d = rx_last ? IDLE : DATA;
                cnt_d   = rx_last ? cnt_q + 1'b1 : cnt_q;
            end
            BYPASS: state_d = rx_last ? IDLE : BYPASS;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign TX_DATA      = in_hdr ? HDR_DATA : RX_DATA;
    assign TX_REM       = in_hdr ? '1 : RX_REM;
    // The header becomes the frame's first part, so the payload's own SOF is suppressed.
    assign TX_SOF_N     = in_hdr ? 1'b0 : state_q == BYPASS ? RX_SOF_N : 1'b1;
    assign TX_SOP_N     = in_hdr ? 1'b0 : RX_SOP_N;
    assign TX_EOP_N     = in_hdr ? 1'b0 : RX_EOP_N;
    assign TX_EOF_N     = in_hdr ? 1'b1 : RX_EOF_N;
    assign TX_SRC_RDY_N = in_hdr ? 1'b0 : pass ? RX_SRC_RDY_N : 1'b1;
    assign RX_DST_RDY_N = pass ? TX_DST_RDY_N : 1'b1;
    assign HDR_NEXT     = in_hdr && !TX_DST_RDY_N;
    assign FRAME_CNT    = cnt_q;
endmodule

// File: tb/tb_fl_netcope_adder_ctrl.sv
// tb_fl_netcope_adder_ctrl: scoreboard bench for the NetCOPE header insertion controller
module tb_fl_netcope_adder_ctrl;
    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  r;
        logic        sof_n, sop_n, eop_n, eof_n;
    } beat_t;

    logic        CLK = 0, RESET, EN;
    logic [63:0] RX_DATA, HDR_DATA, TX_DATA;
    logic [2:0]  RX_REM, TX_REM;
    logic        RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N, RX_SRC_RDY_N, RX_DST_RDY_N;
    logic        HDR_VLD, HDR_NEXT;
    logic        TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N, TX_DST_RDY_N;
    logic [3:0]  FRAME_CNT;

    beat_t       sb[$];
    int          errors = 0, checks = 0;
    int          hn_pulses = 0, nh = 0, hdr_req = 0, hdr_given = 0;
    logic [3:0]  cnt_m = 0;
    bit          hdr_gate = 1, tx_mode = 0;

    fl_netcope_adder_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_SOP_N(RX_SOP_N),
        .RX_EOP_N(RX_EOP_N), .RX_EOF_N(RX_EOF_N), .RX_SRC_RDY_N(RX_SRC_RDY_N),
        .RX_DST_RDY_N(RX_DST_RDY_N), .HDR_DATA(HDR_DATA), .HDR_VLD(HDR_VLD),
        .HDR_NEXT(HDR_NEXT), .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N),
        .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N), .TX_EOF_N(TX_EOF_N),
        .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] hdr_word(input int i);
        return i == 0 ? 64'h00000000_DEADBEEF : {16'hC0DE, 16'(i), 32'(i * 3 + 1)};
    endfunction

    // Header source: offers hdr_word(n) while requests are outstanding, advances on HDR_NEXT.
    initial begin
        bit took;
        HDR_VLD  = 0;
        HDR_DATA = 0;
        forever begin
            @(negedge CLK);
            took = HDR_NEXT;
            @(posedge CLK);
            #2;
            if (took) hdr_given++;
            HDR_VLD  = hdr_gate && hdr_given < hdr_req;
            HDR_DATA = hdr_word(hdr_given);
        end
    end

    // Downstream ready: always ready, or toggling every cycle.
    initial begin
        TX_DST_RDY_N = 0;
        forever begin
            @(posedge CLK);
            #1;
            TX_DST_RDY_N = tx_mode ? ~TX_DST_RDY_N : 1'b0;
        end
    end

    // Monitor: scoreboard pop on each TX transfer plus handshake invariants.
    initial begin
        beat_t got, exp;
        forever begin
            @(negedge CLK);
            if (!RESET && !TX_SRC_RDY_N && !TX_DST_RDY_N) begin
                got = {TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %h, required no output", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL tx_beat: got %h, required %h", got, exp);
                    end
                end
            end
            if (HDR_NEXT) begin
                hn_pulses++;
                checks++;
                if (TX_SRC_RDY_N || TX_DST_RDY_N || TX_SOF_N || !TX_EOF_N) begin
                    errors++;
                    $display("FAIL hdr_next_cycle: src=%b dst=%b sof=%b eof=%b, required 0 0 0 1",
                             TX_SRC_RDY_N, TX_DST_RDY_N, TX_SOF_N, TX_EOF_N);
                end
            end
            if (!TX_SRC_RDY_N && TX_SOF_N) begin
                checks++;
                if (RX_DST_RDY_N !== TX_DST_RDY_N) begin
                    errors++;
                    $display("FAIL rx_dst_mirror: got %b, required %b", RX_DST_RDY_N, TX_DST_RDY_N);
                end
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic put_word(input logic [63:0] d, input logic [2:0] r, input bit sof, input bit eof);
        bit acc = 0;
        int t = 0;
        RX_DATA = d;
        RX_REM = r;
        RX_SOF_N = !sof;
        RX_SOP_N = !sof;
        RX_EOP_N = !eof;
        RX_EOF_N = !eof;
        RX_SRC_RDY_N = 0;
        while (!acc && t < 300) begin
            @(negedge CLK);
            acc = !RX_DST_RDY_N;
            sync();
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: got no accept, required accept of %h", d);
        end
    endtask

    task automatic push_hdr();
        hdr_req++;
        sb.push_back('{hdr_word(nh), 3'd7, 1'b0, 1'b0, 1'b0, 1'b1});
        nh++;
    endtask

    task automatic send_frame(input int n, input logic [63:0] base, input bit ins, input bit drop_en);
        if (ins) begin
            push_hdr();
            cnt_m++;
        end
        for (int i = 0; i < n; i++)
            sb.push_back('{base + 64'(i), (i == n - 1) ? 3'd5 : 3'd7,
                           ins ? 1'b1 : !(i == 0), !(i == 0), !(i == n - 1), !(i == n - 1)});
        for (int i = 0; i < n; i++) begin
            put_word(base + 64'(i), (i == n - 1) ? 3'd5 : 3'd7, i == 0, i == n - 1);
            if (i == 0 && drop_en) EN = 0;
        end
        RX_SRC_RDY_N = 1;
        RX_SOF_N = 1;
    endtask

    task automatic drain_and_check(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        @(negedge CLK);
        chk({name, "_drain"}, 64'(sb.size()), 64'd0);
        chk({name, "_cnt"}, 64'(FRAME_CNT), 64'(cnt_m));
        chk({name, "_hdr_pulses"}, 64'(hn_pulses), 64'(nh));
        sync();
    endtask

    initial begin
        RESET = 1;
        EN = 1;
        RX_DATA = 0;
        RX_REM = 0;
        RX_SOF_N = 1;
        RX_SOP_N = 1;
        RX_EOP_N = 1;
        RX_EOF_N = 1;
        RX_SRC_RDY_N = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tx_src", 64'(TX_SRC_RDY_N), 64'd1);
        chk("rst_rx_dst", 64'(RX_DST_RDY_N), 64'd1);
        chk("rst_hdr_next", 64'(HDR_NEXT), 64'd0);
        chk("rst_cnt", 64'(FRAME_CNT), 64'd0);
        sync();
        RESET = 0;
        sync();

        send_frame(3, 64'h1000, 1, 0);
        drain_and_check("basic");

        hdr_gate = 0;
        fork
            send_frame(2, 64'h2000, 1, 0);
            begin
                int t = 0;
                repeat (5) begin
                    @(negedge CLK);
                    chk("stall_rx_dst", 64'(RX_DST_RDY_N), 64'd1);
                    chk("stall_tx_src", 64'(TX_SRC_RDY_N), 64'd1);
                end
                sync();
                hdr_gate = 1;
                do begin
                    @(negedge CLK);
                    t++;
                end while (!HDR_VLD && t < 10);
                @(negedge CLK);
                chk("stall_hdr_src", 64'(TX_SRC_RDY_N), 64'd0);
                chk("stall_hdr_sof", 64'(TX_SOF_N), 64'd0);
            end
        join
        drain_and_check("stall");

        tx_mode = 1;
        send_frame(3, 64'h3000, 1, 0);
        send_frame(1, 64'h3100, 1, 0);
        tx_mode = 0;
        drain_and_check("toggle");

        EN = 0;
        send_frame(2, 64'h4000, 0, 0);
        EN = 1;
        drain_and_check("bypass");

        send_frame(3, 64'h5000, 1, 1);
        EN = 1;
        drain_and_check("en_drop");

        push_hdr();
        sb.push_back('{64'h6000, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1});
        put_word(64'h6000, 3'd7, 1, 0);
        RX_SRC_RDY_N = 1;
        RX_SOF_N = 1;
        RESET = 1;
        cnt_m = 0;
        @(negedge CLK);
        chk("midrst_tx_src", 64'(TX_SRC_RDY_N), 64'd1);
        chk("midrst_rx_dst", 64'(RX_DST_RDY_N), 64'd1);
        chk("midrst_cnt", 64'(FRAME_CNT), 64'd0);
        sync();
        RESET = 0;
        sync();
        send_frame(3, 64'h7000, 1, 0);
        drain_and_check("after_rst");

        for (int i = 0; i < 14; i++) send_frame(1 + i % 2, 64'h8000 + 64'(i * 16), 1, 0);
        drain_and_check("pre_wrap");
        chk("cnt_max", 64'(FRAME_CNT), 64'd15);
        send_frame(2, 64'h9000, 1, 0);
        drain_and_check("wrap");
        chk("cnt_wrapped", 64'(FRAME_CNT), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fl_netcope_adder_ctrl.md
Name: fl_netcope_adder_ctrl

Overview:
Controller that sequences NetCOPE header insertion on a FrameLink stream. It takes one header word per frame from a header source (timestamp/interface unit) and prepends it to the incoming frame as a separate first part. It then passes the payload parts through unchanged except for SOF. It sits between the input buffer and the FrameLink output toward the application, and it also provides bypass control and a frame counter.

Parameters:
DATA_WIDTH, 64, FrameLink data width in bits (16, 32, 64, 128)
CNT_WIDTH, 32, width of inserted-frame counter

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-high
EN  in  1  1 = insert header, 0 = bypass; sampled only in IDLE
RX_DATA  in  DATA_WIDTH  input FrameLink data
RX_REM  in  log2(DATA_WIDTH/8)  input valid-byte index
RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N  in  1 each  input framing, active-low
RX_SRC_RDY_N  in  1  input source ready, active-low
RX_DST_RDY_N  out  1  input destination ready, active-low
HDR_DATA  in  DATA_WIDTH  header word for next frame
HDR_VLD  in  1  HDR_DATA valid
HDR_NEXT  out  1  one-cycle pop strobe for header source
TX_DATA  out  DATA_WIDTH  output data
TX_REM  out  log2(DATA_WIDTH/8)  output valid-byte index
TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N  out  1 each  output framing, active-low
TX_SRC_RDY_N  out  1  output source ready, active-low
TX_DST_RDY_N  in  1  output destination ready, active-low
FRAME_CNT  out  CNT_WIDTH  frames with inserted header, wraps at max

Behaviour:
- FSM states: IDLE, HDR, DATA, BYPASS. Reset → IDLE, FRAME_CNT=0, HDR_NEXT=0.
- Transfer (RX or TX) = SRC_RDY_N=0 and DST_RDY_N=0 in the same cycle.
- IDLE: TX_SRC_RDY_N=1, RX_DST_RDY_N=1, HDR_NEXT=0. A frame start is pending when RX_SRC_RDY_N=0 and RX_SOF_N=0.
  - If a frame start is pending and EN=0 → BYPASS.
  - Else if a frame start is pending and EN=1 and HDR_VLD=1 → HDR.
  - Else stay in IDLE. A missing header stalls the frame; nothing is dropped.
- HDR: TX_DATA=HDR_DATA, TX_REM=all ones, TX_SOF_N=0, TX_SOP_N=0, TX_EOP_N=0, TX_EOF_N=1, TX_SRC_RDY_N=0, RX_DST_RDY_N=1.
  - On TX_DST_RDY_N=0: HDR_NEXT=1 for exactly that cycle (combinational), and → DATA.
  - HDR_DATA is held by the source until HDR_NEXT.
- DATA: TX_DATA/REM/SOP_N/EOP_N/EOF_N = RX equivalents; TX_SOF_N forced 1; TX_SRC_RDY_N=RX_SRC_RDY_N; RX_DST_RDY_N=TX_DST_RDY_N (combinational, zero latency).
  - On a transfer with RX_EOF_N=0: FRAME_CNT+1 (mod 2^CNT_WIDTH) and → IDLE.
- BYPASS: full pass-through including SOF. On a transfer with RX_EOF_N=0 → IDLE; FRAME_CNT unchanged.
- EN changes mid-frame have no effect until the next IDLE.
- Minimum one IDLE cycle between consecutive frames. Header latency is one output word per frame.
- Single-word frame (SOF and EOF together) in DATA: one transfer, then → IDLE.
- RESET asserted mid-frame: immediate return to IDLE, outputs inactive, FRAME_CNT=0. The partial frame on TX is abandoned; the downstream consumer handles it.
- Output framing is valid only while TX_SRC_RDY_N=0.

Test Plan:
- EN=1, HDR_VLD=1 with HDR_DATA=0x00000000_DEADBEEF, 3-word frame (SOF on w0, EOF on w2), TX_DST_RDY_N=0 → TX carries 4 words: header (SOF=0, EOP=0, EOF=1), then w0 with SOF=1, w1, w2 (EOF=0); one HDR_NEXT pulse; FRAME_CNT=1.
- Frame pending, HDR_VLD=0 for 5 cycles then 1 → RX_DST_RDY_N=1 and TX_SRC_RDY_N=1 throughout the stall; the header is emitted in the cycle after HDR_VLD rises; payload intact.
- TX_DST_RDY_N toggled 1/0 every cycle in HDR and DATA → HDR_NEXT asserted only on the accepted header cycle; RX_DST_RDY_N mirrors TX_DST_RDY_N; no word is lost or duplicated.
- EN=0, 2-word frame → output is identical to input including SOF; HDR_NEXT never asserted; FRAME_CNT unchanged. EN toggled to 0 mid-frame in DATA → the current frame still completes with its header.
- Preload FRAME_CNT to 2^CNT_WIDTH-1 (via 2^CNT_WIDTH-1 frames with CNT_WIDTH=4) plus one more frame → FRAME_CNT wraps to 0.
- RESET pulsed while in DATA after 1 of 3 words → FSM in IDLE, TX_SRC_RDY_N=1, FRAME_CNT=0; the next full frame is processed correctly with a new header.
